// File: rtl/keypad_pkg.sv
// Shared key codes, entry-state encoding and BCD digit type for the keypad front end.
package keypad_pkg;

    localparam int unsigned NUM_DIGIT_KEYS = 10;
    localparam int unsigned KEY_BKSP       = 10;
    localparam int unsigned KEY_CLR        = 11;
    localparam int unsigned KEY_ENT        = 12;

    typedef enum logic [1:0] {
        EMPTY,
        EDIT,
        DONE
    } entry_state_e;

    typedef logic [3:0] bcd_t;

    function automatic logic is_digit(input int unsigned code);
        return code < NUM_DIGIT_KEYS;
    endfunction

endpackage

// File: rtl/keypad_scan_debounce.sv
// Row scanner with whole-frame debounce; emits one pulse per single-key press.
module keypad_scan_debounce #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_SCANS = 8,
    parameter int KW        = $clog2(ROWS*COLS)
) (
    input  logic            clk_50M,
    input  logic            RST,
    input  logic [COLS-1:0] col,
    output logic [ROWS-1:0] row,
    output logic            key_valid,
    output logic [KW-1:0]   key_code
);

    localparam int NK = ROWS * COLS;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW = $clog2(DEB_SCANS + 1);

    logic [DW-1:0] div;
    logic [RW-1:0] row_idx, row_idx_next;
    logic [NK-1:0] frame, frame_next, prev_frame, deb, deb_prev;
    logic [SW-1:0] stable, stable_next;
    logic          tc, frame_end, new_press, single_key;
    logic [KW-1:0] code_next;

    assign tc           = (div == DW'(SCAN_DIV - 1));
    assign frame_end    = tc && (row_idx == RW'(ROWS - 1));
    assign row_idx_next = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);

    // Frame as it will look once the current row's sample is folded in.
    always_comb begin
        frame_next = frame;
        frame_next[row_idx*COLS +: COLS] = ~col;
    end

    always_comb begin
        stable_next = stable;
        if (frame_end) begin
            if (frame_next == prev_frame)
                stable_next = (stable == SW'(DEB_SCANS)) ? stable : stable + SW'(1);
            else
                stable_next = '0;
        end
    end

    // Chords (more than one key down) never produce an event.
    assign new_press  = |(deb & ~deb_prev);
    assign single_key = (deb != '0) && ((deb & (deb - NK'(1))) == '0);

    always_comb begin
        code_next = '0;
        for (int i = 0; i < NK; i++)
            if (deb[i]) code_next = KW'(i);
    end

    always_ff @(posedge clk_50M or posedge RST) begin
        if (RST) begin
            div        <= '0;
            row_idx    <= '0;
            row        <= ~ROWS'(1);
            frame      <= '0;
            prev_frame <= '0;
            stable     <= '0;
            deb        <= '0;
            deb_prev   <= '0;
            key_valid  <= 1'b0;
            key_code   <= '0;
        end else begin
            deb_prev  <= deb;
            key_valid <= new_press && single_key;
            if (new_press && single_key)
                key_code <= code_next;
            if (tc) begin
                div     <= '0;
                frame   <= frame_next;
                row_idx <= row_idx_next;
                row     <= ~(ROWS'(1) << row_idx_next);
            end else begin
                div <= div + DW'(1);
            end
            if (frame_end) begin
                prev_frame <= frame_next;
                stable     <= stable_next;
                if (stable_next == SW'(DEB_SCANS))
                    deb <= frame_next;
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end top: scan/debounce sub-block plus the BCD entry FSM.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_SCANS = 8,
    parameter int KW        = $clog2(ROWS*COLS),
    localparam int LW       = $clog2(DIGITS + 1),
    localparam int EW       = 4 * DIGITS
) (
    input  logic            clk_50M,
    input  logic            RST,
    input  logic [COLS-1:0] col,
    output logic [ROWS-1:0] row,
    output logic            key_valid,
    output logic [KW-1:0]   key_code,
    output logic [EW-1:0]   entry,
    output logic [LW-1:0]   entry_len,
    output logic            entry_done,
    output logic            overflow
);

    entry_state_e state, state_next;
    logic [EW-1:0] entry_next;
    logic [LW-1:0] len_next;
    logic          done_next, ovf_next;
    int unsigned   kc;
    bcd_t          digit;

    keypad_scan_debounce #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB_SCANS),
        .KW        (KW)
    ) u_scan (
        .clk_50M   (clk_50M),
        .RST       (RST),
        .col       (col),
        .row       (row),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    assign kc    = 32'(key_code);
    assign digit = kc[3:0];

    always_comb begin
        state_next = state;
        entry_next = entry;
        len_next   = entry_len;
        done_next  = 1'b0;
        ovf_next   = 1'b0;
        if (key_valid) begin
            if (is_digit(kc)) begin
                if (state == DONE) begin
                    // A digit after Enter starts a fresh entry.
                    entry_next = EW'(digit);
                    len_next   = LW'(1);
                    state_next = EDIT;
                end else if (entry_len < LW'(DIGITS)) begin
                    entry_next = (entry << 4) | EW'(digit);
                    len_next   = entry_len + LW'(1);
                    state_next = EDIT;
                end else begin
                    ovf_next = 1'b1;
                end
            end else if (kc == KEY_BKSP) begin
                if (state != EMPTY) begin
                    entry_next = entry >> 4;
                    len_next   = entry_len - LW'(1);
                    state_next = (entry_len == LW'(1)) ? EMPTY : EDIT;
                end
            end else if (kc == KEY_CLR) begin
                entry_next = '0;
                len_next   = '0;
                state_next = EMPTY;
            end else if (kc == KEY_ENT) begin
                if (state == EDIT && entry_len != '0) begin
                    done_next  = 1'b1;
                    state_next = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk_50M or posedge RST) begin
        if (RST) begin
            state      <= EMPTY;
            entry      <= '0;
            entry_len  <= '0;
            entry_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            entry      <= entry_next;
            entry_len  <= len_next;
            entry_done <= done_next;
            overflow   <= ovf_next;
        end
    end

endmodule
